axi_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream AXI3 write path (AW, W, B channels) between NUM_M upstream masters.
- A grant covers one whole transaction: AW handshake, all W beats, then the B handshake. Only one transaction is outstanding at a time.
- Sits between the DMA/test masters and the DDR controller slave port.
- Generates WLAST from a beat counter and flags any upstream WLAST mismatch.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/axi_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 write-path constants and arbiter FSM state type.
// Imported by the write arbiter and its round-robin picker.
package axi_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AWCACHE_DEF = 4'b0011;
  localparam logic [2:0] AWPROT_DEF  = 3'b000;
  localparam logic [1:0] AWLOCK_DEF  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_gnt.
// The caller registers the resulting one-hot grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last_gnt,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] w_last;
  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    w_last = '0;
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i]) w_last = IW'(i);
    end
  end

  // Scan starts one past the previous winner and wraps.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(w_last) + k) % N);
      if (!w_found && req[w_pos]) begin
        gnt[w_pos] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI3 write arbiter: one whole AW/W/B transaction
// per grant, WLAST regenerated from a beat counter.
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_M*ADDR_W-1:0]    s_awaddr,
  input  logic [NUM_M*4-1:0]         s_awid,
  input  logic [NUM_M*4-1:0]         s_awlen,
  input  logic [NUM_M*3-1:0]         s_awsize,
  input  logic [NUM_M*2-1:0]         s_awburst,
  input  logic [NUM_M-1:0]           s_awvalid,
  output logic [NUM_M-1:0]           s_awready,
  input  logic [NUM_M*DATA_W-1:0]    s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  s_wstrb,
  input  logic [NUM_M-1:0]           s_wlast,
  input  logic [NUM_M-1:0]           s_wvalid,
  output logic [NUM_M-1:0]           s_wready,
  output logic [3:0]                 s_bid,
  output logic [1:0]                 s_bresp,
  output logic [NUM_M-1:0]           s_bvalid,
  input  logic [NUM_M-1:0]           s_bready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [3:0]                 m_awid,
  output logic [3:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic [3:0]                 m_awcache,
  output logic [2:0]                 m_awprot,
  output logic [1:0]                 m_awlock,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic [3:0]                 m_wid,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [3:0]                 m_bid,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic [NUM_M-1:0]           gnt,
  output logic                       busy,
  output logic                       wlast_err
);

  localparam int IW = $clog2(NUM_M);
  localparam int SW = DATA_W / 8;

  state_t           r_state;
  state_t           w_next;
  logic [NUM_M-1:0] r_gnt;
  logic [NUM_M-1:0] r_last_gnt;
  logic [NUM_M-1:0] w_arb_gnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic [ID_W-1:0]  r_id;
  logic             r_wlast_err;
  logic [IW-1:0]    w_idx;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req      (s_awvalid),
    .last_gnt (r_last_gnt),
    .gnt      (w_arb_gnt)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gnt[i]) w_idx = IW'(i);
    end
  end

  assign m_awaddr  = s_awaddr[w_idx*ADDR_W +: ADDR_W];
  assign m_awid    = s_awid[w_idx*ID_W +: ID_W];
  assign m_awlen   = s_awlen[w_idx*LEN_W +: LEN_W];
  assign m_awsize  = s_awsize[w_idx*3 +: 3];
  assign m_awburst = s_awburst[w_idx*2 +: 2];
  assign m_awcache = AWCACHE_DEF;
  assign m_awprot  = AWPROT_DEF;
  assign m_awlock  = AWLOCK_DEF;
  assign m_wdata   = s_wdata[w_idx*DATA_W +: DATA_W];
  assign m_wstrb   = s_wstrb[w_idx*SW +: SW];
  assign m_wid     = r_id;
  assign s_bid     = m_bid;
  assign s_bresp   = m_bresp;

  // Every valid/ready path is qualified by phase, so W never leaks early.
  assign m_awvalid = (r_state == ADDR) && s_awvalid[w_idx];
  assign m_wvalid  = (r_state == DATA) && s_wvalid[w_idx];
  assign m_wlast   = (r_state == DATA) && (r_beat == r_len);
  assign m_bready  = (r_state == RESP) && s_bready[w_idx];

  assign s_awready = r_gnt & {NUM_M{(r_state == ADDR) && m_awready}};
  assign s_wready  = r_gnt & {NUM_M{(r_state == DATA) && m_wready}};
  assign s_bvalid  = r_gnt & {NUM_M{(r_state == RESP) && m_bvalid}};

  assign w_aw_hs = m_awvalid && m_awready;
  assign w_w_hs  = m_wvalid && m_wready;
  assign w_b_hs  = (r_state == RESP) && m_bvalid && m_bready;

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign wlast_err = r_wlast_err;

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (|s_awvalid)         w_next = ADDR;
      ADDR:    if (w_aw_hs)            w_next = DATA;
      DATA:    if (w_w_hs && m_wlast)  w_next = RESP;
      RESP:    if (w_b_hs)             w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_gnt       <= '0;
      r_last_gnt  <= {1'b1, {(NUM_M-1){1'b0}}};
      r_len       <= '0;
      r_id        <= '0;
      r_beat      <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      if (r_state == IDLE && |s_awvalid) r_gnt <= w_arb_gnt;
      if (w_aw_hs) begin
        r_len  <= m_awlen;
        r_id   <= m_awid;
        r_beat <= '0;
      end
      if (w_w_hs) begin
        r_beat <= r_beat + LEN_W'(1);
        if (s_wlast[w_idx] != m_wlast) r_wlast_err <= 1'b1;
      end
      if (w_b_hs) begin
        r_last_gnt <= r_gnt;
        r_gnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter against a transaction-level
// model: RR grant order, beat payloads, WLAST and response routing.
module tb_axi_wr_arbiter;
  import axi_pkg::*;

  localparam int NM   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXT = 40;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NM*AW-1:0]  s_awaddr;
  logic [NM*4-1:0]   s_awid, s_awlen;
  logic [NM*3-1:0]   s_awsize;
  logic [NM*2-1:0]   s_awburst;
  logic [NM-1:0]     s_awvalid, s_awready;
  logic [NM*DW-1:0]  s_wdata;
  logic [NM*SW-1:0]  s_wstrb;
  logic [NM-1:0]     s_wlast, s_wvalid, s_wready;
  logic [3:0]        s_bid;
  logic [1:0]        s_bresp;
  logic [NM-1:0]     s_bvalid, s_bready;
  logic [AW-1:0]     m_awaddr;
  logic [3:0]        m_awid, m_awlen, m_awcache;
  logic [2:0]        m_awsize, m_awprot;
  logic [1:0]        m_awburst, m_awlock;
  logic              m_awvalid, m_awready;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [3:0]        m_wid;
  logic              m_wlast, m_wvalid, m_wready;
  logic [3:0]        m_bid;
  logic [1:0]        m_bresp;
  logic              m_bvalid, m_bready;
  logic [NM-1:0]     gnt;
  logic              busy, wlast_err;

  always #5 aclk = ~aclk;

  axi_wr_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awlock(m_awlock),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .gnt(gnt), .busy(busy), .wlast_err(wlast_err)
  );

  logic [31:0] t_addr [NM][MAXT];
  logic [3:0]  t_len  [NM][MAXT];
  logic [3:0]  t_id   [NM][MAXT];
  int          t_err  [NM][MAXT];
  int          n_txn  [NM];
  int          head   [NM];
  int          w_idx  [NM];
  bit          aw_done[NM];
  bit          wv     [NM];

  // Transaction tracker: 0 none, 1 address, 2 data, 3 response.
  int mph, win, last, down_beat, ds_beats, exp_beats, stall;
  bit exp_err, b_pend, bv, force_b;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bdata(int m, int k, int b);
    return {8'(m), 8'(k), 8'(b), 8'hC3};
  endfunction

  function automatic logic [3:0] bstrb(int m, int k, int b);
    return 4'(k * 3 + b + m + 1);
  endfunction

  function automatic int rr_pick(int lst, logic [NM-1:0] req);
    for (int k = 1; k <= NM; k++) begin
      if (req[(lst + k) % NM]) return (lst + k) % NM;
    end
    return 0;
  endfunction

  function automatic int pending();
    int p = 0;
    for (int m = 0; m < NM; m++) p += n_txn[m] - head[m];
    return p;
  endfunction

  task automatic add_txn(int m, logic [31:0] a, int len, int err);
    int n = n_txn[m];
    t_addr[m][n] = a;
    t_len[m][n]  = 4'(len);
    t_id[m][n]   = 4'(m * 5 + n);
    t_err[m][n]  = err;
    n_txn[m]++;
    exp_beats += len + 1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      head[m] = n_txn[m];
      w_idx[m] = 0;
      aw_done[m] = 0;
      wv[m] = 0;
    end
    mph = 0; win = 0; last = NM - 1; down_beat = 0;
    exp_err = 0; b_pend = 0; bv = 0; stall = 0;
    ds_beats = 0; exp_beats = 0;
  endtask

  task automatic drive_zero();
    s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0;
    s_awburst = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_bid = '0; m_bresp = '0;
  endtask

  task automatic drive();
    int c;
    drive_zero();
    for (int m = 0; m < NM; m++) begin
      c = head[m];
      if (c < n_txn[m]) begin
        s_awaddr[m*AW +: AW] = t_addr[m][c];
        s_awid[m*4 +: 4]     = t_id[m][c];
        s_awlen[m*4 +: 4]    = t_len[m][c];
        s_awsize[m*3 +: 3]   = 3'(m);
        s_awburst[m*2 +: 2]  = (m == 2) ? BURST_WRAP : BURST_INCR;
        s_awvalid[m]         = !aw_done[m];
        if (w_idx[m] <= int'(t_len[m][c])) begin
          if (!wv[m]) wv[m] = ($urandom_range(0, 3) != 0);
          s_wvalid[m] = wv[m];
          s_wdata[m*DW +: DW] = bdata(m, c, w_idx[m]);
          s_wstrb[m*SW +: SW] = bstrb(m, c, w_idx[m]);
          s_wlast[m] = (w_idx[m] == int'(t_len[m][c])) ^
                       (t_err[m][c] == w_idx[m]);
        end else begin
          s_bready[m] = aw_done[m] && ($urandom_range(0, 2) != 0);
        end
      end
    end
    if (stall > 0) stall--;
    else if ($urandom_range(0, 19) == 0) stall = 5;
    m_awready = (stall == 0) && ($urandom_range(0, 2) != 0);
    m_wready  = (stall == 0) && ($urandom_range(0, 2) != 0);
    if (b_pend && !bv && stall == 0 && $urandom_range(0, 1) == 1) begin
      bv = 1;
    end
    m_bvalid = bv;
    m_bid    = force_b ? 4'h5 : 4'(head[win] + win);
    m_bresp  = force_b ? RESP_SLVERR : 2'(head[win]);
  endtask

  task automatic observe();
    logic [NM-1:0] eg;
    bit aw_hs, w_hs, b_hs;
    int c;
    eg = (mph != 0) ? (NM'(1) << win) : '0;
    c  = head[win];
    chk("gnt", gnt, eg);
    chk("busy", busy, mph != 0);
    chk("wlast_err", wlast_err, exp_err);
    chk("m_awvalid", m_awvalid, mph == 1 && s_awvalid[win]);
    chk("m_wvalid", m_wvalid, mph == 2 && s_wvalid[win]);
    chk("m_bready", m_bready, mph == 3 && s_bready[win]);
    chk("s_awready", s_awready, (mph == 1 && m_awready) ? eg : '0);
    chk("s_wready", s_wready, (mph == 2 && m_wready) ? eg : '0);
    chk("s_bvalid", s_bvalid, (mph == 3 && m_bvalid) ? eg : '0);
    aw_hs = m_awvalid && m_awready;
    w_hs  = m_wvalid && m_wready;
    b_hs  = m_bvalid && m_bready;
    if (mph == 1 && aw_hs) begin
      chk("awaddr", m_awaddr, t_addr[win][c]);
      chk("awlen", m_awlen, t_len[win][c]);
      chk("awid", m_awid, t_id[win][c]);
      chk("awsize", m_awsize, 3'(win));
      chk("awburst", m_awburst, (win == 2) ? BURST_WRAP : BURST_INCR);
      chk("awattr", {m_awcache, m_awprot, m_awlock}, 9'b0011_000_00);
    end
    if (mph == 2 && w_hs) begin
      chk("wdata", m_wdata, bdata(win, c, down_beat));
      chk("wstrb", m_wstrb, bstrb(win, c, down_beat));
      chk("wlast", m_wlast, down_beat == int'(t_len[win][c]));
      chk("wid", m_wid, t_id[win][c]);
    end
    if (mph == 3 && b_hs) begin
      chk("s_bid", s_bid, m_bid);
      chk("s_bresp", s_bresp, m_bresp);
    end
    for (int m = 0; m < NM; m++) begin
      if (s_wvalid[m] && s_wready[m]) begin
        chk("w_after_aw", aw_done[m], 1);
        w_idx[m]++;
        wv[m] = 0;
      end
      if (s_awvalid[m] && s_awready[m]) aw_done[m] = 1;
      if (s_bvalid[m] && s_bready[m]) begin
        head[m]++;
        aw_done[m] = 0;
        w_idx[m] = 0;
        wv[m] = 0;
      end
    end
    if (w_hs && m_wlast) b_pend = 1;
    if (b_hs) begin
      b_pend = 0;
      bv = 0;
    end
    case (mph)
      0: if (|s_awvalid) begin
        win = rr_pick(last, s_awvalid);
        mph = 1;
      end
      1: if (aw_hs) begin
        mph = 2;
        down_beat = 0;
      end
      2: if (w_hs) begin
        if (s_wlast[win] != (down_beat == int'(t_len[win][c])))
          exp_err = 1;
        if (down_beat == int'(t_len[win][c])) mph = 3;
        down_beat++;
        ds_beats++;
      end
      default: if (b_hs) begin
        last = win;
        mph = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    drive();
    @(negedge aclk);
    observe();
  endtask

  task automatic drain(int budget);
    int cyc = 0;
    while (pending() != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("drain_left", pending(), 0);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_valids"}, {m_awvalid, m_wvalid, m_bready}, 3'b000);
    chk({tag, "_readies"}, {s_awready, s_wready, s_bvalid}, '0);
    chk({tag, "_gnt"}, gnt, '0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, wlast_err, 0);
  endtask

  initial begin
    int len, err, guard;
    force_b = 0;
    for (int m = 0; m < NM; m++) n_txn[m] = 0;
    model_reset();
    aresetn = 0;
    drive_zero();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_idle_outputs("reset");
    @(posedge aclk);
    #1 aresetn = 1;

    add_txn(0, 32'h1000, 3, -1);
    add_txn(1, 32'h2000, 0, -1);
    add_txn(0, 32'h1100, 0, -1);
    add_txn(1, 32'h2100, 3, 1);
    for (int m = 0; m < NM; m++) begin
      for (int k = 0; k < 10; k++) begin
        case ($urandom_range(0, 3))
          0:       len = 0;
          1:       len = 15;
          default: len = $urandom_range(1, 14);
        endcase
        err = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
        add_txn(m, {$urandom_range(0, 65535), 4'h0, 12'h0}, len, err);
      end
    end
    drain(20000);
    chk("beats", ds_beats, exp_beats);
    chk("err_sticky", wlast_err, 1);

    add_txn(0, 32'h3000, 15, -1);
    guard = 0;
    while (!(mph == 2 && down_beat >= 2) && guard < 500) begin
      step();
      guard++;
    end
    chk("reach_beat2", mph == 2 && down_beat >= 2, 1);
    @(posedge aclk);
    #1 aresetn = 0;
    @(posedge aclk);
    @(negedge aclk);
    chk_idle_outputs("midreset");
    model_reset();
    drive_zero();
    @(posedge aclk);
    #1 aresetn = 1;

    force_b = 1;
    add_txn(1, 32'h4000, 15, -1);
    step();
    step();
    chk("m1_granted", gnt, 3'b010);
    drain(2000);
    chk("beats16", ds_beats, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
